vga_sync_gen: RTL and testbench

//   VGA 640x480@60 timing source. Divides the system clock to the pixel rate, runs the

---
 rtl/vga_sync_gen.sv | 113 +++++++++++
 tb/tb_vga_sync_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing source.
// Divides the system clock down to the pixel rate, runs the horizontal and
// vertical raster counters that address the pattern generators, and registers
// the returned colour together with the decoded syncs. Pins therefore lag the
// counters by exactly one pixel.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,    // system clocks per pixel
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0  // active level of the sync pins
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       video_on,
  output logic       frame_start,
  input  logic [2:0] color_in,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [2:0] vga_rgb
);

  // Raster geometry; both totals must fit the 10-bit counters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic hs_d;
  logic vs_d;

  // Pixel-rate divider. With CLK_DIV == 1 every system clock is a pixel.
  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] div_cnt;

      // Free-running divider counter, wraps after CLK_DIV clocks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end

      assign pix_tick = (div_cnt == DIV_LAST);
    end else begin : g_nodiv
      assign pix_tick = 1'b1;
    end
  endgenerate

  // Raster counters: advance only on pixel ticks, vcnt steps on each line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 10'd1;
        end
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Decode of the current raster position (visible area, sync windows, frame origin).
  always_comb begin
    video_on    = (hcnt < H_VIS) && (vcnt < V_VIS);
    hs_d        = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    vs_d        = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    frame_start = pix_tick && (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  // Pin stage: syncs and colour registered together so they stay pixel-aligned;
  // colour is forced to black outside the visible area (input may be X there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs  <= ~SYNC_POL;
      vga_vs  <= ~SYNC_POL;
      vga_rgb <= 3'b000;
    end else if (pix_tick) begin
      vga_hs  <= hs_d ? SYNC_POL : ~SYNC_POL;
      vga_vs  <= vs_d ? SYNC_POL : ~SYNC_POL;
      vga_rgb <= video_on ? color_in : 3'b000;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Instance A uses the full 640x480 geometry at CLK_DIV=4; instance B uses
// CLK_DIV=1 and a tiny raster so a whole frame wrap fits in a short run.
// Expected pin/counter values per pixel tick are hand-computed vectors queued
// by the stimulus; monitors pop them when the DUT reaches that tick.
module tb_vga_sync_gen;

  typedef struct {
    int         n;     // pixel tick index since reset release
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    logic       fs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       rst_a_n;
  logic       pix_tick_a, video_on_a, frame_start_a, hs_a, vs_a;
  logic [9:0] hcnt_a, vcnt_a;
  logic [2:0] color_a, rgb_a;

  // Instance B signals
  logic       rst_b_n;
  logic       pix_tick_b, video_on_b, frame_start_b, hs_b, vs_b;
  logic [9:0] hcnt_b, vcnt_b;
  logic [2:0] color_b, rgb_b;

  vga_sync_gen u_dut_a (
    .clk        (clk),
    .rst_n      (rst_a_n),
    .pix_tick   (pix_tick_a),
    .hcnt       (hcnt_a),
    .vcnt       (vcnt_a),
    .video_on   (video_on_a),
    .frame_start(frame_start_a),
    .color_in   (color_a),
    .vga_hs     (hs_a),
    .vga_vs     (vs_a),
    .vga_rgb    (rgb_a)
  );

  vga_sync_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_b_n),
    .pix_tick   (pix_tick_b),
    .hcnt       (hcnt_b),
    .vcnt       (vcnt_b),
    .video_on   (video_on_b),
    .frame_start(frame_start_b),
    .color_in   (color_b),
    .vga_hs     (hs_b),
    .vga_vs     (vs_b),
    .vga_rgb    (rgb_b)
  );

  int errors = 0;
  int checks = 0;

  vec_t qa[$];
  vec_t qb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  function automatic vec_t mk(input int n, input int h, input int v, input int hs,
                              input int vs, input int rgb, input int fs);
    vec_t e;
    e.n = n; e.h = 10'(h); e.v = 10'(v); e.hs = 1'(hs); e.vs = 1'(vs);
    e.rgb = 3'(rgb); e.fs = 1'(fs);
    return e;
  endfunction

  task automatic cmp_vec(input string tag, input vec_t e, input logic [9:0] h,
                         input logic [9:0] v, input logic hs, input logic vs,
                         input logic [2:0] rgb, input logic fs);
    string p;
    p = $sformatf("%s n=%0d", tag, e.n);
    chk({p, " hcnt"}, int'(h), int'(e.h));
    chk({p, " vcnt"}, int'(v), int'(e.v));
    chk({p, " vga_hs"}, int'(hs), int'(e.hs));
    chk({p, " vga_vs"}, int'(vs), int'(e.vs));
    chk({p, " vga_rgb"}, int'(rgb), int'(e.rgb));
    chk({p, " frame_start"}, int'(fs), int'(e.fs));
  endtask

  // Monitor A: tick timing from reset, tick spacing, and vector comparison.
  int   n_a = 0;
  int   cyc_a = -1;
  int   last_a = -1;
  vec_t ea;
  always @(negedge clk) begin
    if (!rst_a_n) begin
      n_a = 0; cyc_a = -1; last_a = -1;
    end else begin
      cyc_a++;
      if (pix_tick_a) begin
        if (last_a < 0) chk("A first tick edges after release", cyc_a, 3);
        else if (cyc_a - last_a != 4) chk("A tick spacing", cyc_a - last_a, 4);
        last_a = cyc_a;
        if (qa.size() > 0 && qa[0].n == n_a) begin
          ea = qa.pop_front();
          cmp_vec("A", ea, hcnt_a, vcnt_a, hs_a, vs_a, rgb_a, frame_start_a);
        end
        n_a++;
      end
    end
  end

  // Monitor B: pix_tick stuck high with CLK_DIV=1, plus vector comparison.
  int   n_b = 0;
  vec_t eb;
  always @(negedge clk) begin
    if (!rst_b_n) begin
      n_b = 0;
    end else begin
      if (n_b < 200 && !pix_tick_b) chk("B pix_tick stuck high", int'(pix_tick_b), 1);
      if (pix_tick_b) begin
        if (qb.size() > 0 && qb[0].n == n_b) begin
          eb = qb.pop_front();
          cmp_vec("B", eb, hcnt_b, vcnt_b, hs_b, vs_b, rgb_b, frame_start_b);
        end
        n_b++;
      end
    end
  end

  // Stimulus: queue expected vectors, release reset, mid-frame async reset on A.
  initial begin
    bit reached;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    color_a = 3'b101;
    color_b = 3'b011;

    // Instance A, full geometry: n, hcnt, vcnt, hs, vs, rgb, frame_start
    qa.push_back(mk(0,   0,   0, 1, 1, 0, 1));
    qa.push_back(mk(1,   1,   0, 1, 1, 5, 0));
    qa.push_back(mk(640, 640, 0, 1, 1, 5, 0));
    qa.push_back(mk(641, 641, 0, 1, 1, 0, 0));
    qa.push_back(mk(656, 656, 0, 1, 1, 0, 0));
    qa.push_back(mk(657, 657, 0, 0, 1, 0, 0));
    qa.push_back(mk(752, 752, 0, 0, 1, 0, 0));
    qa.push_back(mk(753, 753, 0, 1, 1, 0, 0));
    qa.push_back(mk(799, 799, 0, 1, 1, 0, 0));
    qa.push_back(mk(800, 0,   1, 1, 1, 0, 0));
    qa.push_back(mk(801, 1,   1, 1, 1, 5, 0));

    // Instance B, 16x11 raster: hs window h10..12, vs window lines 7..8
    qb.push_back(mk(0,   0,  0,  1, 1, 0, 1));
    qb.push_back(mk(1,   1,  0,  1, 1, 3, 0));
    qb.push_back(mk(8,   8,  0,  1, 1, 3, 0));
    qb.push_back(mk(9,   9,  0,  1, 1, 0, 0));
    qb.push_back(mk(10,  10, 0,  1, 1, 0, 0));
    qb.push_back(mk(11,  11, 0,  0, 1, 0, 0));
    qb.push_back(mk(13,  13, 0,  0, 1, 0, 0));
    qb.push_back(mk(14,  14, 0,  1, 1, 0, 0));
    qb.push_back(mk(96,  0,  6,  1, 1, 0, 0));
    qb.push_back(mk(97,  1,  6,  1, 1, 0, 0));
    qb.push_back(mk(112, 0,  7,  1, 1, 0, 0));
    qb.push_back(mk(113, 1,  7,  1, 0, 0, 0));
    qb.push_back(mk(144, 0,  9,  1, 0, 0, 0));
    qb.push_back(mk(145, 1,  9,  1, 1, 0, 0));
    qb.push_back(mk(175, 15, 10, 1, 1, 0, 0));
    qb.push_back(mk(176, 0,  0,  1, 1, 0, 1));
    qb.push_back(mk(177, 1,  0,  1, 1, 3, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("A reset hcnt", int'(hcnt_a), 0);
    chk("A reset vcnt", int'(vcnt_a), 0);
    chk("A reset vga_hs", int'(hs_a), 1);
    chk("A reset vga_vs", int'(vs_a), 1);
    chk("A reset vga_rgb", int'(rgb_a), 0);
    chk("A reset pix_tick", int'(pix_tick_a), 0);
    chk("A reset video_on", int'(video_on_a), 1);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Run A to (400,1) with a bounded wait, then assert reset between edges.
    reached = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (hcnt_a == 10'd400 && vcnt_a == 10'd1) begin
        reached = 1'b1;
        break;
      end
    end
    chk("A reached hcnt=400 vcnt=1", int'(reached), 1);
    chk("A rgb before mid-frame reset", int'(rgb_a), 5);
    chk("A vectors pending before reset", qa.size(), 0);
    #1 rst_a_n = 1'b0;
    #1;
    chk("A async reset hcnt", int'(hcnt_a), 0);
    chk("A async reset vcnt", int'(vcnt_a), 0);
    chk("A async reset vga_rgb", int'(rgb_a), 0);
    chk("A async reset vga_hs", int'(hs_a), 1);
    chk("A async reset vga_vs", int'(vs_a), 1);
    chk("A async reset pix_tick", int'(pix_tick_a), 0);

    qa.push_back(mk(0, 0, 0, 1, 1, 0, 1));
    qa.push_back(mk(1, 1, 0, 1, 1, 5, 0));
    qa.push_back(mk(2, 2, 0, 1, 1, 5, 0));
    repeat (2) @(posedge clk);
    #1 rst_a_n = 1'b1;

    repeat (30) @(posedge clk);
    #1;
    chk("A vectors left unchecked", qa.size(), 0);
    chk("B vectors left unchecked", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
